// File: rtl/riscv_pkg.sv
// Shared types for the memory-side blocks of the core.
//
// mem_src_e : originator of a memory request (instruction fetch or load/store).
// mem_gnt_e : grant state of the IFU/LSU memory arbiter.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    SRC_IFU,
    SRC_LSU
  } mem_src_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IFU,
    GNT_LSU
  } mem_gnt_e;

endpackage

// File: rtl/riscv_order_fifo.sv
// Small synchronous FIFO used to remember the order of issued requests.
//
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data: write one entry (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   head_data      : current head entry, valid while !empty
//   full, empty    : occupancy flags
//   count          : current occupancy, 0..DEPTH
//
// DEPTH must be a power of two, at least 2. Pointers carry one extra MSB so that
// full and empty can be told apart when the index bits match.
module riscv_order_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;
  logic [PW-1:0]    fill;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Natural modulo-2^PW subtraction gives the occupancy across wrap-around.
  assign fill      = wr_ptr_q - rd_ptr_q;
  assign count     = CW'(fill);
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/riscv_mem_arb.sv
// Arbiter sharing the single AXI driver port between instruction fetch (IFU,
// read-only) and load/store (LSU, read/write).
//
// Ports:
//   clock, reset_n          : rising-edge clock, asynchronous active-low reset
//   ifu_req_* / ifu_rsp_*   : IFU read request and response handshakes
//   lsu_req_* / lsu_rsp_*   : LSU read/write request and response handshakes
//   drv_req_* / drv_rsp_*   : request to / in-order response from the driver
//   outstanding             : requests accepted by the driver but not yet answered
//   err                     : sticky; set by a driver response with nothing outstanding
//
// LSU has priority, except that after LSU_STREAK consecutive LSU grants with IFU
// waiting, IFU wins the next arbitration. Once a request is presented but not
// acked, the grant is held until the driver accepts it. The source of every
// accepted request is queued so in-order responses can be steered back.
module riscv_mem_arb
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LSU_STREAK = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  // IFU request / response
  input  logic                       ifu_req_vld,
  input  logic [31:0]                ifu_req_addr,
  output logic                       ifu_req_ack,
  output logic                       ifu_rsp_vld,
  output logic [31:0]                ifu_rsp_addr,
  output logic [31:0]                ifu_rsp_data,
  input  logic                       ifu_rsp_ack,
  // LSU request / response
  input  logic                       lsu_req_vld,
  input  logic                       lsu_req_rnw,
  input  logic [31:0]                lsu_req_addr,
  input  logic [31:0]                lsu_req_data,
  output logic                       lsu_req_ack,
  output logic                       lsu_rsp_vld,
  output logic [31:0]                lsu_rsp_addr,
  output logic [31:0]                lsu_rsp_data,
  input  logic                       lsu_rsp_ack,
  // Driver request / response
  output logic                       drv_req_vld,
  output logic                       drv_req_rnw,
  output logic [31:0]                drv_req_addr,
  output logic [31:0]                drv_req_data,
  input  logic                       drv_req_ack,
  input  logic                       drv_rsp_vld,
  input  logic [31:0]                drv_rsp_addr,
  input  logic [31:0]                drv_rsp_data,
  output logic                       drv_rsp_ack,
  // Status
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       err
);

  localparam int unsigned SW = $clog2(LSU_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(LSU_STREAK);

  mem_gnt_e      gnt_q;
  logic [SW-1:0] streak_q;
  logic          err_q;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [0:0]    push_bits;
  logic [0:0]    head_bits;
  mem_src_e      head_src;

  logic          lsu_first;
  logic          sel_ifu;
  logic          sel_lsu;
  logic          rsp_to_ifu;
  logic          rsp_to_lsu;

  // ---------------------------------------------------------------------------
  // Arbitration: pick the source driven onto the driver this cycle
  // ---------------------------------------------------------------------------
  // IFU overrides LSU priority only when it is waiting and the streak is spent.
  assign lsu_first = lsu_req_vld && !(ifu_req_vld && (streak_q == STREAK_MAX));

  always_comb begin
    sel_ifu = 1'b0;
    sel_lsu = 1'b0;
    // A full FIFO blocks issue even when a pop happens the same cycle; reset
    // forces every handshake low regardless of the requesters.
    if (reset_n && !fifo_full) begin
      unique case (gnt_q)
        GNT_NONE: begin
          sel_lsu = lsu_first;
          sel_ifu = !lsu_first && ifu_req_vld;
        end
        GNT_IFU: sel_ifu = ifu_req_vld;
        GNT_LSU: sel_lsu = lsu_req_vld;
        default: begin
          sel_ifu = 1'b0;
          sel_lsu = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    drv_req_vld  = sel_ifu || sel_lsu;
    drv_req_rnw  = 1'b0;
    drv_req_addr = '0;
    drv_req_data = '0;
    if (sel_lsu) begin
      drv_req_rnw  = lsu_req_rnw;
      drv_req_addr = lsu_req_addr;
      drv_req_data = lsu_req_data;
    end else if (sel_ifu) begin
      drv_req_rnw  = 1'b1;
      drv_req_addr = ifu_req_addr;
    end
  end

  assign ifu_req_ack = sel_ifu && drv_req_ack;
  assign lsu_req_ack = sel_lsu && drv_req_ack;

  assign fifo_push = drv_req_vld && drv_req_ack;
  assign push_bits = sel_lsu ? SRC_LSU : SRC_IFU;

  // ---------------------------------------------------------------------------
  // Response routing by the source at the head of the order FIFO
  // ---------------------------------------------------------------------------
  assign head_src   = mem_src_e'(head_bits);
  assign rsp_to_ifu = reset_n && !fifo_empty && (head_src == SRC_IFU);
  assign rsp_to_lsu = reset_n && !fifo_empty && (head_src == SRC_LSU);

  always_comb begin
    ifu_rsp_vld  = rsp_to_ifu && drv_rsp_vld;
    ifu_rsp_addr = rsp_to_ifu ? drv_rsp_addr : '0;
    ifu_rsp_data = rsp_to_ifu ? drv_rsp_data : '0;
    lsu_rsp_vld  = rsp_to_lsu && drv_rsp_vld;
    lsu_rsp_addr = rsp_to_lsu ? drv_rsp_addr : '0;
    lsu_rsp_data = rsp_to_lsu ? drv_rsp_data : '0;
    // With nothing outstanding a stray beat is swallowed so the driver never stalls.
    if (!reset_n) begin
      drv_rsp_ack = 1'b0;
    end else if (fifo_empty) begin
      drv_rsp_ack = 1'b1;
    end else if (head_src == SRC_LSU) begin
      drv_rsp_ack = lsu_rsp_ack;
    end else begin
      drv_rsp_ack = ifu_rsp_ack;
    end
  end

  assign fifo_pop = drv_rsp_vld && drv_rsp_ack && !fifo_empty;

  riscv_order_fifo #(
    .WIDTH (1),
    .DEPTH (DEPTH)
  ) u_order_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (push_bits),
    .pop       (fifo_pop),
    .head_data (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

  // ---------------------------------------------------------------------------
  // Grant state, streak counter and error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q    <= GNT_NONE;
      streak_q <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (gnt_q)
        GNT_NONE: begin
          if (sel_lsu && !drv_req_ack) begin
            gnt_q <= GNT_LSU;
          end else if (sel_ifu && !drv_req_ack) begin
            gnt_q <= GNT_IFU;
          end
        end
        GNT_IFU: begin
          if (ifu_req_ack) begin
            gnt_q <= GNT_NONE;
          end
        end
        GNT_LSU: begin
          if (lsu_req_ack) begin
            gnt_q <= GNT_NONE;
          end
        end
        default: gnt_q <= GNT_NONE;
      endcase

      if (!ifu_req_vld || ifu_req_ack) begin
        streak_q <= '0;
      end else if (lsu_req_ack && (streak_q != STREAK_MAX)) begin
        streak_q <= streak_q + SW'(1);
      end

      if (drv_rsp_vld && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_riscv_mem_arb.sv
// Directed bench for riscv_mem_arb: inputs change 1 time unit after a rising
// edge, outputs are sampled 1 time unit later, well away from the next edge.
module tb_riscv_mem_arb;

  logic        clock;
  logic        reset_n;
  logic        ifu_req_vld;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ack;
  logic        ifu_rsp_vld;
  logic [31:0] ifu_rsp_addr;
  logic [31:0] ifu_rsp_data;
  logic        ifu_rsp_ack;
  logic        lsu_req_vld;
  logic        lsu_req_rnw;
  logic [31:0] lsu_req_addr;
  logic [31:0] lsu_req_data;
  logic        lsu_req_ack;
  logic        lsu_rsp_vld;
  logic [31:0] lsu_rsp_addr;
  logic [31:0] lsu_rsp_data;
  logic        lsu_rsp_ack;
  logic        drv_req_vld;
  logic        drv_req_rnw;
  logic [31:0] drv_req_addr;
  logic [31:0] drv_req_data;
  logic        drv_req_ack;
  logic        drv_rsp_vld;
  logic [31:0] drv_rsp_addr;
  logic [31:0] drv_rsp_data;
  logic        drv_rsp_ack;
  logic [2:0]  outstanding;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Hand-computed occupancy for the IFU-only sequence.
  int occ_ifu [6] = '{0, 1, 2, 2, 1, 0};

  riscv_mem_arb #(
    .DEPTH      (4),
    .LSU_STREAK (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ifu_req_vld  (ifu_req_vld),
    .ifu_req_addr (ifu_req_addr),
    .ifu_req_ack  (ifu_req_ack),
    .ifu_rsp_vld  (ifu_rsp_vld),
    .ifu_rsp_addr (ifu_rsp_addr),
    .ifu_rsp_data (ifu_rsp_data),
    .ifu_rsp_ack  (ifu_rsp_ack),
    .lsu_req_vld  (lsu_req_vld),
    .lsu_req_rnw  (lsu_req_rnw),
    .lsu_req_addr (lsu_req_addr),
    .lsu_req_data (lsu_req_data),
    .lsu_req_ack  (lsu_req_ack),
    .lsu_rsp_vld  (lsu_rsp_vld),
    .lsu_rsp_addr (lsu_rsp_addr),
    .lsu_rsp_data (lsu_rsp_data),
    .lsu_rsp_ack  (lsu_rsp_ack),
    .drv_req_vld  (drv_req_vld),
    .drv_req_rnw  (drv_req_rnw),
    .drv_req_addr (drv_req_addr),
    .drv_req_data (drv_req_data),
    .drv_req_ack  (drv_req_ack),
    .drv_rsp_vld  (drv_rsp_vld),
    .drv_rsp_addr (drv_rsp_addr),
    .drv_rsp_data (drv_rsp_data),
    .drv_rsp_ack  (drv_rsp_ack),
    .outstanding  (outstanding),
    .err          (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ifu_req_vld  = 1'b0;
    ifu_req_addr = '0;
    ifu_rsp_ack  = 1'b0;
    lsu_req_vld  = 1'b0;
    lsu_req_rnw  = 1'b1;
    lsu_req_addr = '0;
    lsu_req_data = '0;
    lsu_rsp_ack  = 1'b0;
    drv_req_ack  = 1'b0;
    drv_rsp_vld  = 1'b0;
    drv_rsp_addr = '0;
    drv_rsp_data = '0;
  endtask

  initial begin
    logic exp_ifu;

    // ---------------- Reset ----------------
    reset_n = 1'b0;
    idle();
    #1;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_drv_req_vld", drv_req_vld, 0);
    chk("rst_drv_rsp_ack", drv_rsp_ack, 0);
    chk("rst_err", err, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    chk("idle_drv_rsp_ack", drv_rsp_ack, 1);

    // ---------------- IFU alone, responses 2 cycles after issue ----------------
    tick();
    ifu_rsp_ack = 1'b1;
    drv_req_ack = 1'b1;
    for (int c = 0; c < 6; c++) begin
      ifu_req_vld  = (c < 3);
      ifu_req_addr = 32'h200 + 32'(4 * c);
      drv_rsp_vld  = (c >= 2) && (c < 5);
      drv_rsp_addr = 32'h200 + 32'(4 * (c - 2));
      drv_rsp_data = 32'hD000_0000 + 32'(c - 2);
      #1;
      chk("ifu_only_req_ack", ifu_req_ack, (c < 3));
      chk("ifu_only_outstanding", outstanding, occ_ifu[c]);
      chk("ifu_only_lsu_rsp_vld", lsu_rsp_vld, 0);
      chk("ifu_only_rsp_vld", ifu_rsp_vld, (c >= 2) && (c < 5));
      if (c < 3) begin
        chk("ifu_only_drv_addr", drv_req_addr, 32'h200 + 32'(4 * c));
        chk("ifu_only_drv_rnw", drv_req_rnw, 1);
        chk("ifu_only_drv_data", drv_req_data, 0);
      end
      if ((c >= 2) && (c < 5)) begin
        chk("ifu_only_rsp_addr", ifu_rsp_addr, 32'h200 + 32'(4 * (c - 2)));
        chk("ifu_only_rsp_data", ifu_rsp_data, 32'hD000_0000 + 32'(c - 2));
      end
      tick();
    end

    // ---------------- Priority and streak: L L L L I L L L L I ----------------
    idle();
    ifu_req_vld  = 1'b1;
    ifu_req_addr = 32'h400;
    lsu_req_vld  = 1'b1;
    lsu_req_addr = 32'h1000;
    drv_req_ack  = 1'b1;
    ifu_rsp_ack  = 1'b1;
    lsu_rsp_ack  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drv_rsp_vld = (c != 0);
      #1;
      exp_ifu = (c == 4) || (c == 9);
      chk("prio_ifu_ack", ifu_req_ack, exp_ifu);
      chk("prio_lsu_ack", lsu_req_ack, !exp_ifu);
      chk("prio_drv_addr", drv_req_addr, exp_ifu ? 32'h400 : 32'h1000);
      tick();
    end
    ifu_req_vld = 1'b0;
    lsu_req_vld = 1'b0;
    #1;
    chk("prio_outstanding", outstanding, 1);
    tick();
    drv_rsp_vld = 1'b0;
    #1;
    chk("prio_drained", outstanding, 0);
    chk("prio_err", err, 0);
    tick();

    // ---------------- Grant hold while driver stalls ----------------
    idle();
    lsu_req_vld  = 1'b1;
    lsu_req_addr = 32'h2000;
    ifu_req_vld  = 1'b1;
    ifu_req_addr = 32'h500;
    for (int c = 0; c < 4; c++) begin
      drv_req_ack = (c == 3);
      #1;
      chk("hold_drv_vld", drv_req_vld, 1);
      chk("hold_drv_addr", drv_req_addr, 32'h2000);
      chk("hold_lsu_ack", lsu_req_ack, (c == 3));
      chk("hold_ifu_ack", ifu_req_ack, 0);
      tick();
    end
    lsu_req_vld = 1'b0;
    drv_req_ack = 1'b1;
    #1;
    chk("hold_then_ifu_addr", drv_req_addr, 32'h500);
    chk("hold_then_ifu_ack", ifu_req_ack, 1);
    tick();
    ifu_req_vld = 1'b0;
    drv_req_ack = 1'b0;
    drv_rsp_vld = 1'b1;
    ifu_rsp_ack = 1'b1;
    lsu_rsp_ack = 1'b1;
    #1;
    chk("hold_rsp1_lsu", lsu_rsp_vld, 1);
    chk("hold_rsp1_ifu", ifu_rsp_vld, 0);
    chk("hold_rsp1_outstanding", outstanding, 2);
    tick();
    chk("hold_rsp2_ifu", ifu_rsp_vld, 1);
    chk("hold_rsp2_lsu", lsu_rsp_vld, 0);
    tick();
    drv_rsp_vld = 1'b0;
    #1;
    chk("hold_drained", outstanding, 0);
    tick();

    // ---------------- Full FIFO ----------------
    idle();
    ifu_req_vld  = 1'b1;
    ifu_req_addr = 32'h600;
    drv_req_ack  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("full_fill_ack", ifu_req_ack, 1);
      chk("full_fill_outstanding", outstanding, c);
      tick();
    end
    #1;
    chk("full_blocked_vld", drv_req_vld, 0);
    chk("full_blocked_ack", ifu_req_ack, 0);
    chk("full_outstanding", outstanding, 4);
    tick();
    drv_rsp_vld = 1'b1;
    ifu_rsp_ack = 1'b1;
    #1;
    chk("full_pop_rsp_ack", drv_rsp_ack, 1);
    chk("full_pop_same_cycle_vld", drv_req_vld, 0);
    tick();
    drv_rsp_vld = 1'b0;
    #1;
    chk("full_reissue_outstanding", outstanding, 3);
    chk("full_reissue_vld", drv_req_vld, 1);
    chk("full_reissue_ack", ifu_req_ack, 1);
    tick();
    ifu_req_vld = 1'b0;
    drv_rsp_vld = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("full_drain_outstanding", outstanding, 4 - c);
      chk("full_drain_rsp_vld", ifu_rsp_vld, 1);
      tick();
    end
    drv_rsp_vld = 1'b0;
    #1;
    chk("full_drained", outstanding, 0);
    tick();

    // ---------------- Interleaved routing, LSU stall, spurious response ----------------
    idle();
    ifu_req_vld  = 1'b1;
    ifu_req_addr = 32'h300;
    drv_req_ack  = 1'b1;
    #1;
    chk("mix_ifu_ack", ifu_req_ack, 1);
    tick();
    ifu_req_vld  = 1'b0;
    lsu_req_vld  = 1'b1;
    lsu_req_rnw  = 1'b0;
    lsu_req_addr = 32'h1000;
    lsu_req_data = 32'hCAFE_F00D;
    #1;
    chk("mix_lsu_ack", lsu_req_ack, 1);
    chk("mix_drv_rnw", drv_req_rnw, 0);
    chk("mix_drv_data", drv_req_data, 32'hCAFE_F00D);
    tick();
    lsu_req_vld  = 1'b0;
    drv_req_ack  = 1'b0;
    ifu_rsp_ack  = 1'b1;
    lsu_rsp_ack  = 1'b0;
    drv_rsp_vld  = 1'b1;
    drv_rsp_addr = 32'h300;
    drv_rsp_data = 32'h1111_2222;
    #1;
    chk("mix_rsp1_ifu_vld", ifu_rsp_vld, 1);
    chk("mix_rsp1_ifu_addr", ifu_rsp_addr, 32'h300);
    chk("mix_rsp1_ifu_data", ifu_rsp_data, 32'h1111_2222);
    chk("mix_rsp1_lsu_vld", lsu_rsp_vld, 0);
    chk("mix_rsp1_drv_ack", drv_rsp_ack, 1);
    tick();
    drv_rsp_addr = 32'h1000;
    drv_rsp_data = 32'h0;
    for (int c = 0; c < 3; c++) begin
      lsu_rsp_ack = (c == 2);
      #1;
      chk("mix_rsp2_lsu_vld", lsu_rsp_vld, 1);
      chk("mix_rsp2_lsu_addr", lsu_rsp_addr, 32'h1000);
      chk("mix_rsp2_ifu_vld", ifu_rsp_vld, 0);
      chk("mix_rsp2_drv_ack", drv_rsp_ack, (c == 2));
      chk("mix_rsp2_outstanding", outstanding, 1);
      tick();
    end
    drv_rsp_vld = 1'b0;
    #1;
    chk("mix_drained", outstanding, 0);
    chk("mix_err_clear", err, 0);
    tick();
    drv_rsp_vld  = 1'b1;
    drv_rsp_addr = 32'hDEAD_0000;
    #1;
    chk("spur_drv_ack", drv_rsp_ack, 1);
    chk("spur_ifu_vld", ifu_rsp_vld, 0);
    chk("spur_lsu_vld", lsu_rsp_vld, 0);
    tick();
    drv_rsp_vld = 1'b0;
    #1;
    chk("spur_err_set", err, 1);
    chk("spur_outstanding", outstanding, 0);
    tick();
    chk("spur_err_sticky", err, 1);

    // ---------------- Reset with 3 requests outstanding ----------------
    idle();
    ifu_req_vld  = 1'b1;
    ifu_req_addr = 32'h700;
    drv_req_ack  = 1'b1;
    repeat (3) tick();
    drv_rsp_vld = 1'b1;
    ifu_rsp_ack = 1'b1;
    #1;
    chk("prerst_outstanding", outstanding, 3);
    chk("prerst_drv_vld", drv_req_vld, 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_outstanding", outstanding, 0);
    chk("async_rst_drv_vld", drv_req_vld, 0);
    chk("async_rst_ifu_ack", ifu_req_ack, 0);
    chk("async_rst_lsu_ack", lsu_req_ack, 0);
    chk("async_rst_ifu_rsp", ifu_rsp_vld, 0);
    chk("async_rst_lsu_rsp", lsu_rsp_vld, 0);
    chk("async_rst_drv_rsp_ack", drv_rsp_ack, 0);
    chk("async_rst_err", err, 0);
    idle();
    tick();
    reset_n = 1'b1;
    ifu_req_vld  = 1'b1;
    ifu_req_addr = 32'h800;
    drv_req_ack  = 1'b1;
    #1;
    chk("post_rst_ack", ifu_req_ack, 1);
    chk("post_rst_outstanding0", outstanding, 0);
    tick();
    ifu_req_vld  = 1'b0;
    drv_req_ack  = 1'b0;
    drv_rsp_vld  = 1'b1;
    drv_rsp_addr = 32'h800;
    drv_rsp_data = 32'h8888_8888;
    ifu_rsp_ack  = 1'b1;
    #1;
    chk("post_rst_outstanding1", outstanding, 1);
    chk("post_rst_rsp_vld", ifu_rsp_vld, 1);
    chk("post_rst_rsp_data", ifu_rsp_data, 32'h8888_8888);
    chk("post_rst_err", err, 0);
    tick();
    drv_rsp_vld = 1'b0;
    #1;
    chk("post_rst_drained", outstanding, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
